// File: rtl/cpu_debug_access_arbiter.sv
// Round-robin arbiter sharing one CPU OCI debug memory port between N_REQ
// requesters. Each grant runs ISSUE -> WAIT -> RESP with a bounded wait.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   req/req_write      per-requester request level and direction (1=write)
//   req_addr/req_wdata packed per-requester address and write data
//   ack                one-cycle completion pulse to the granted requester
//   resp_rdata/err     response payload, valid while ack is high
//   oci_*              command strobe/payload out, ready/error/rdata in
//   debugack           CPU halted in debug mode; writes refused otherwise
//   busy, grant_id     activity flag and current/last granted index
module cpu_debug_access_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*32-1:0]        req_wdata,
  output logic [N_REQ-1:0]           ack,
  output logic [31:0]                resp_rdata,
  output logic                       resp_err,
  output logic                       oci_strobe,
  output logic                       oci_write,
  output logic [ADDR_W-1:0]          oci_addr,
  output logic [31:0]                oci_wdata,
  input  logic                       oci_ready,
  input  logic                       oci_error,
  input  logic [31:0]                oci_rdata,
  input  logic                       debugack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned GNT_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [GNT_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GNT_W-1:0]    sel, idx;
  logic                found;

  logic [N_REQ-1:0]    ack_d;
  logic [DATA_W-1:0]   resp_rdata_d;
  logic                resp_err_d;
  logic                oci_strobe_d;
  logic                oci_write_d;
  logic [ADDR_W-1:0]   oci_addr_d;
  logic [DATA_W-1:0]   oci_wdata_d;
  logic                busy_d;
  logic [GNT_W-1:0]    grant_d;

  // Unpacked views of the packed request payloads
  logic [ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last grant
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = GNT_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    grant_d      = grant_id;
    oci_write_d  = oci_write;
    oci_addr_d   = oci_addr;
    oci_wdata_d  = oci_wdata;
    ack_d        = '0;
    oci_strobe_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = sel;
          oci_write_d = req_write[sel];
          oci_addr_d  = addr_arr[sel];
          oci_wdata_d = wdata_arr[sel];
          // Writes to a running CPU are refused without touching the port
          if (req_write[sel] && !debugack) begin
            state_d    = S_RESP;
            ack_d[sel] = 1'b1;
            resp_err_d = 1'b1;
          end else begin
            state_d      = S_ISSUE;
            oci_strobe_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (oci_ready) begin
          state_d         = S_RESP;
          ack_d[grant_id] = 1'b1;
          resp_rdata_d    = oci_write ? '0 : oci_rdata;
          resp_err_d      = oci_error;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d         = S_RESP;
          ack_d[grant_id] = 1'b1;
          resp_err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        ptr_d   = grant_id;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= GNT_W'(N_REQ - 1);
      cnt_q      <= '0;
      grant_id   <= '0;
      ack        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      oci_strobe <= 1'b0;
      oci_write  <= 1'b0;
      oci_addr   <= '0;
      oci_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_id   <= grant_d;
      ack        <= ack_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      oci_strobe <= oci_strobe_d;
      oci_write  <= oci_write_d;
      oci_addr   <= oci_addr_d;
      oci_wdata  <= oci_wdata_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_access_arbiter.sv
// Self-checking bench for cpu_debug_access_arbiter: a transaction-level
// model predicts outputs every cycle, directed tests pin key literals.
module tb_cpu_debug_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 9;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic            oci_strobe, oci_write;
  logic [AW-1:0]   oci_addr;
  logic [31:0]     oci_wdata;
  logic            oci_ready = 1'b0, oci_error = 1'b0;
  logic [31:0]     oci_rdata = '0;
  logic            debugack = 1'b1;
  logic            busy;
  logic [0:0]      grant_id;

  cpu_debug_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .oci_strobe(oci_strobe),
    .oci_write(oci_write), .oci_addr(oci_addr), .oci_wdata(oci_wdata),
    .oci_ready(oci_ready), .oci_error(oci_error), .oci_rdata(oci_rdata),
    .debugack(debugack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_active = 0;
  int          m_ptr = N-1, m_grant = 0;
  int          m_resp_at = -1, m_wait_from = 0;
  bit          m_write = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  bit          m_err = 0;
  logic [N-1:0] e_ack = '0;
  bit          e_strobe = 0, e_busy = 0;

  // At each edge: predict the outputs of the cycle that starts now
  always @(posedge clk or negedge reset_n) begin
    int n;
    if (!reset_n) begin
      m_active = 0; m_ptr = N-1; m_grant = 0; m_resp_at = -1;
      m_write = 0; m_addr = '0; m_wdata = '0;
      e_ack = '0; e_strobe = 0; e_busy = 0;
    end else begin
      n = cyc;
      cyc = cyc + 1;
      e_strobe = 0;
      if (!m_active) begin
        if (req != 0) begin
          for (int k = N; k >= 1; k--)
            if (req[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
          m_active = 1;
          m_write  = req_write[m_grant];
          m_addr   = req_addr[m_grant*AW +: AW];
          m_wdata  = req_wdata[m_grant*32 +: 32];
          if (m_write && !debugack) begin
            m_resp_at = n + 1; m_rdata = '0; m_err = 1;
          end else begin
            e_strobe = 1; m_wait_from = n + 2; m_resp_at = -1;
          end
        end
      end else if (m_resp_at == n) begin
        m_active = 0; m_ptr = m_grant;
      end else if (m_resp_at < 0 && n >= m_wait_from) begin
        if (oci_ready) begin
          m_resp_at = n + 1; m_rdata = m_write ? 32'h0 : oci_rdata; m_err = oci_error;
        end else if (n - m_wait_from == TO - 1) begin
          m_resp_at = n + 1; m_rdata = '0; m_err = 1;
        end
      end
      e_busy = m_active;
      e_ack  = (m_active && m_resp_at == n + 1) ? N'(1 << m_grant) : '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 64'(ack), 64'(e_ack));
      chk("oci_strobe", 64'(oci_strobe), 64'(e_strobe));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("grant_id", 64'(grant_id), 64'(m_grant));
      chk("oci_write", 64'(oci_write), 64'(m_write));
      chk("oci_addr", 64'(oci_addr), 64'(m_addr));
      chk("oci_wdata", 64'(oci_wdata), 64'(m_wdata));
      if (e_ack != 0) begin
        chk("resp_rdata", 64'(resp_rdata), 64'(m_rdata));
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end
    end
  end

  // ---------------- OCI responder ----------------
  int          rsp_delay = 1;     // cycles after strobe; -1 = never ready
  bit          rsp_err_val = 0;
  logic [31:0] rsp_rdata_val = '0;
  bit          armed = 0;
  int          cd = 0;

  always @(negedge clk or negedge reset_n) begin
    oci_ready = 0; oci_error = 0; oci_rdata = '0;
    if (!reset_n) armed = 0;
    else begin
      if (oci_strobe && rsp_delay >= 0) begin armed = 1; cd = rsp_delay; end
      else if (armed) cd--;
      if (armed && cd == 0) begin
        oci_ready = 1; oci_error = rsp_err_val; oci_rdata = rsp_rdata_val; armed = 0;
      end
    end
  end

  // ---------------- event monitor ----------------
  int          s_cnt = 0, s_cyc = 0;
  logic [AW-1:0] s_addr = '0;
  int          a_hist[$];

  always @(negedge clk) begin
    if (oci_strobe) begin s_cnt++; s_cyc = cyc; s_addr = oci_addr; end
    if (ack != 0) a_hist.push_back(ack[1] ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
    req_write[i]        = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic start(input int i, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] d, output int t0);
    @(negedge clk);
    set_cmd(i, wr, a, d);
    req = N'(1 << i);
    t0 = cyc;
  endtask

  task automatic wait_ack(output int c, output int id, output logic [31:0] rd, output logic er);
    c = -1; id = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        c = cyc; id = ack[1] ? 1 : 0; rd = resp_rdata; er = resp_err; req = '0;
        break;
      end
    end
    chk("ack_arrived", 64'(c >= 0), 64'd1);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t0, c, id, s0;
    logic [31:0] rd;
    logic er;

    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    @(negedge clk);
    reset_n = 1;

    // Single read, ready two cycles after strobe
    rsp_delay = 2; rsp_rdata_val = 32'hDEADBEEF; rsp_err_val = 0;
    s0 = s_cnt;
    start(0, 0, 9'h100, 32'h0, t0);
    wait_ack(c, id, rd, er);
    chk("rd_strobes", 64'(s_cnt - s0), 64'd1);
    chk("rd_addr", 64'(s_addr), 64'h100);
    chk("rd_lat", 64'(c - s_cyc), 64'd3);
    chk("rd_id", 64'(id), 64'd0);
    chk("rd_data", 64'(rd), 64'hDEADBEEF);
    chk("rd_err", 64'(er), 64'd0);

    // Refused write to a running CPU
    debugack = 0; s0 = s_cnt;
    start(1, 1, 9'h020, 32'hCAFE0001, t0);
    wait_ack(c, id, rd, er);
    chk("ref_lat", 64'(c - t0), 64'd1);
    chk("ref_id", 64'(id), 64'd1);
    chk("ref_err", 64'(er), 64'd1);
    chk("ref_nostrobe", 64'(s_cnt - s0), 64'd0);
    debugack = 1;

    // Contention: both held, immediate ready
    rsp_delay = 1; rsp_rdata_val = 32'h5A5A0000;
    @(negedge clk);
    set_cmd(0, 0, 9'h011, 32'h0);
    set_cmd(1, 0, 9'h122, 32'h0);
    a_hist.delete();
    req = 2'b11;
    repeat (15) @(negedge clk);
    req = '0;
    #1;
    chk("rr_count", 64'(a_hist.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk("rr_seq", 64'((k < a_hist.size()) ? a_hist[k] : 99), 64'(k % 2));

    // Timeout: never ready
    rsp_delay = -1;
    start(0, 0, 9'h0F0, 32'h0, t0);
    wait_ack(c, id, rd, er);
    chk("to_lat", 64'(c - s_cyc), 64'(TO + 1));
    chk("to_err", 64'(er), 64'd1);
    chk("to_data", 64'(rd), 64'd0);
    @(negedge clk);
    chk("to_busy_after", 64'(busy), 64'd0);

    // Ready during ISSUE only is ignored -> timeout
    rsp_delay = 0; rsp_rdata_val = 32'h11112222;
    start(1, 0, 9'h0C3, 32'h0, t0);
    wait_ack(c, id, rd, er);
    chk("iss_lat", 64'(c - s_cyc), 64'(TO + 1));
    chk("iss_err", 64'(er), 64'd1);

    // OCI error on a write, then clean read at max address
    rsp_delay = 1; rsp_err_val = 1; rsp_rdata_val = 32'hAAAA5555;
    start(0, 1, 9'h055, 32'h12345678, t0);
    wait_ack(c, id, rd, er);
    chk("werr_err", 64'(er), 64'd1);
    chk("werr_data", 64'(rd), 64'd0);
    rsp_delay = 3; rsp_err_val = 0; rsp_rdata_val = 32'h0BADF00D;
    start(0, 0, 9'h1FF, 32'h0, t0);
    wait_ack(c, id, rd, er);
    chk("rd2_err", 64'(er), 64'd0);
    chk("rd2_data", 64'(rd), 64'h0BADF00D);
    chk("rd2_lat", 64'(c - s_cyc), 64'd4);

    // Payload change and req drop after grant
    rsp_delay = 2; rsp_rdata_val = 32'h600DD00D;
    start(1, 0, 9'h0AB, 32'h0, t0);
    @(negedge clk);
    set_cmd(1, 1, 9'h154, 32'hFFFFFFFF);
    req = '0;
    wait_ack(c, id, rd, er);
    chk("drop_id", 64'(id), 64'd1);
    chk("drop_addr", 64'(s_addr), 64'h0AB);
    chk("drop_data", 64'(rd), 64'h600DD00D);

    // Asynchronous reset in WAIT, then requester 0 wins first
    rsp_delay = -1;
    start(1, 0, 9'h1A5, 32'h0, t0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_grant", 64'(grant_id), 64'd1);
    #2 reset_n = 0; req = '0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(grant_id), 64'd0);
    chk("arst_addr", 64'(oci_addr), 64'd0);
    chk("arst_strobe_ack", 64'({oci_strobe, ack}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    rsp_delay = 1; rsp_rdata_val = 32'h00C0FFEE;
    set_cmd(0, 0, 9'h001, 32'h0);
    set_cmd(1, 0, 9'h002, 32'h0);
    req = 2'b11;
    wait_ack(c, id, rd, er);
    chk("post_rst_first", 64'(id), 64'd0);
    chk("post_rst_data", 64'(rd), 64'h00C0FFEE);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
